// File: rtl/i2c_reg_bank.sv
// Register bank behind the 16-bit I2C slave: shadowed config registers that commit
// atomically on the busy falling edge, plus ID/status/sticky-event/mask/counter registers.

module i2c_cfg_slot #(
  parameter logic [15:0] RST = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr,
  input  logic [15:0] wdata,
  input  logic        commit,
  output logic [15:0] shadow,
  output logic [15:0] live
);
  logic [15:0] shadow_next;

  // Commit copies shadow_next so a write landing on the commit cycle is included.
  assign shadow_next = wr ? wdata : shadow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= RST;
      live   <= RST;
    end else begin
      shadow <= shadow_next;
      if (commit) live <= shadow_next;
    end
  end
endmodule

module i2c_reg_bank #(
  parameter int          NUM_REGS  = 16,
  parameter logic [15:0] CFG_RESET = 16'h0000,
  parameter logic [15:0] ID_CODE   = 16'hA55A
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [15:0]           datao,
  input  logic [7:0]            reg_addr,
  input  logic                  busy,
  output logic [15:0]           datai,
  output logic [16*NUM_REGS-1:0] cfg_out,
  output logic                  cfg_commit,
  input  logic [15:0]           status_in,
  input  logic [15:0]           event_in,
  output logic                  irq
);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] A_ID = 8'h80, A_STAT = 8'h81, A_STICKY = 8'h82,
                         A_MASK = 8'h83, A_CNT = 8'h84;

  typedef struct packed {
    logic        en;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_req_t;

  wr_req_t wreq;
  logic busy_d, dirty;
  logic rise, fall, cfg_hit, cfg_wr, commit;
  logic [NUM_REGS-1:0][15:0] shadow, live;
  logic [15:0] snap, sticky, mask, commit_cnt;
  logic [15:0] clr, sticky_next, mask_next, rd;

  assign wreq    = '{en: we, addr: reg_addr, data: datao};
  assign rise    = busy & ~busy_d;
  assign fall    = ~busy & busy_d;
  assign cfg_hit = (wreq.addr < 8'(NUM_REGS));
  assign cfg_wr  = wreq.en & cfg_hit;
  assign commit  = fall & (dirty | cfg_wr);

  genvar i;
  generate
    for (i = 0; i < NUM_REGS; i++) begin : g_slot
      i2c_cfg_slot #(.RST(CFG_RESET)) u_slot (
        .clk    (clk),
        .reset_n(reset_n),
        .wr     (cfg_wr && (wreq.addr[AW-1:0] == AW'(i))),
        .wdata  (wreq.data),
        .commit (commit),
        .shadow (shadow[i]),
        .live   (live[i])
      );
    end
  endgenerate

  assign cfg_out     = live;
  assign clr         = (wreq.en && wreq.addr == A_STICKY) ? wreq.data : 16'h0000;
  assign sticky_next = (sticky & ~clr) | event_in;
  assign mask_next   = (wreq.en && wreq.addr == A_MASK) ? wreq.data : mask;

  always_comb begin
    rd = 16'h0000;
    if (cfg_hit) rd = shadow[wreq.addr[AW-1:0]];
    else begin
      case (wreq.addr)
        A_ID:     rd = ID_CODE;
        A_STAT:   rd = snap;
        A_STICKY: rd = sticky;
        A_MASK:   rd = mask;
        A_CNT:    rd = commit_cnt;
        default:  rd = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_d     <= 1'b0;
      dirty      <= 1'b0;
      datai      <= 16'h0000;
      cfg_commit <= 1'b0;
      irq        <= 1'b0;
      snap       <= 16'h0000;
      sticky     <= 16'h0000;
      mask       <= 16'h0000;
      commit_cnt <= 16'h0000;
    end else begin
      busy_d     <= busy;
      datai      <= rd;
      sticky     <= sticky_next;
      mask       <= mask_next;
      irq        <= |(sticky_next & mask_next);
      cfg_commit <= commit;
      if (rise) snap <= status_in;
      if (commit) begin
        dirty      <= 1'b0;
        commit_cnt <= commit_cnt + 16'd1;
      end else if (cfg_wr) begin
        dirty <= 1'b1;
      end
    end
  end
endmodule
